// File: rtl/mod7681_msub_pipe.sv
// Streaming 3-stage modular multiply-subtract: result = (ri - a*s) mod 7681, one frame of N_COEFF per start.
// Optional macro MSUB_ADD_MODE_EN adds port op; op=1 selects (ri + a*s) mod 7681 instead.
module mod7681_msub_pipe #(
  parameter int Q       = 7681,
  parameter int N_COEFF = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] ri,
  input  logic [12:0] a,
  input  logic [12:0] s,
`ifdef MSUB_ADD_MODE_EN
  input  logic        op,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] result,
  output logic        out_last,
  output logic        busy,
  output logic        done
);
  localparam int STAGES = 3;
  // 2^13 mod Q; the fold bounds below assume Q = 7681 (fold constant 511).
  localparam int FOLD = 8192 - Q;
  localparam logic [13:0] Q14 = 14'(Q);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_COEFF - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [12:0] ri;
    logic [25:0] prod;
    logic        last;
`ifdef MSUB_ADD_MODE_EN
    logic        op;
`endif
  } s1_t;

  typedef struct packed {
    logic [12:0] ri;
    logic [12:0] p;
    logic        last;
`ifdef MSUB_ADD_MODE_EN
    logic        op;
`endif
  } s2_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [STAGES:1]    vld_pipe;
  s1_t                s1;
  s2_t                s2;
  logic               stall, in_fire, out_fire;
  logic [13:0]        diff;
  logic [12:0]        res_nxt;
`ifdef MSUB_ADD_MODE_EN
  logic [13:0]        sum;
`endif

  // Full reduction of a 26-bit product: three 2^13 -> 511 folds, then up to 3 subtractions of Q.
  function automatic logic [12:0] red_prod(input logic [25:0] p);
    logic [22:0] f1;
    logic [19:0] f2;
    logic [16:0] f3;
    f1 = 23'(p[25:13]) * 23'(FOLD) + 23'(p[12:0]);
    f2 = 20'(f1[22:13]) * 20'(FOLD) + 20'(f1[12:0]);
    f3 = 17'(f2[19:13]) * 17'(FOLD) + 17'(f2[12:0]);
    if (f3 >= 17'(3 * Q))      f3 = f3 - 17'(3 * Q);
    else if (f3 >= 17'(2 * Q)) f3 = f3 - 17'(2 * Q);
    else if (f3 >= 17'(Q))     f3 = f3 - 17'(Q);
    return 13'(f3);
  endfunction

  assign stall     = vld_pipe[3] & ~out_ready;
  assign in_ready  = (state == RUN) & ~stall;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = vld_pipe[3];
  assign out_fire  = vld_pipe[3] & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          cnt   <= '0;
        end
        RUN: if (in_fire) begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_IDX) state <= DRAIN;
        end
        DRAIN: if (out_fire && out_last) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // S3 arithmetic: 14-bit signed difference, folded back into 0..Q-1 with one add of Q.
  always_comb begin
    diff    = {1'b0, s2.ri} - {1'b0, s2.p};
    res_nxt = diff[13] ? 13'(diff + Q14) : diff[12:0];
`ifdef MSUB_ADD_MODE_EN
    sum = {1'b0, s2.ri} + {1'b0, s2.p};
    if (s2.op) res_nxt = (sum >= Q14) ? 13'(sum - Q14) : sum[12:0];
`endif
  end

  // Whole pipe freezes on a stall, so a held result stays put until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      result   <= '0;
      out_last <= 1'b0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_fire};
      s1.ri    <= ri;
      s1.prod  <= 26'(a) * 26'(s);
      s1.last  <= in_fire && (cnt == LAST_IDX);
`ifdef MSUB_ADD_MODE_EN
      s1.op    <= op;
      s2.op    <= s1.op;
`endif
      // ri <= 8191 < 2Q, so a single subtraction lands in range.
      s2.ri    <= (s1.ri >= 13'(Q)) ? s1.ri - 13'(Q) : s1.ri;
      s2.p     <= red_prod(s1.prod);
      s2.last  <= s1.last;
      result   <= res_nxt;
      out_last <= s2.last;
    end
  end

endmodule

// File: tb/tb_mod7681_msub_pipe.sv
// Directed bench for mod7681_msub_pipe: queue reference model, per-cycle compare, hand-computed pins.
module tb_mod7681_msub_pipe;
  localparam int Q = 7681;
  localparam int N = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last, busy, done;
  logic [12:0] ri = '0, a = '0, s = '0, result;
`ifdef MSUB_ADD_MODE_EN
  logic op = 1'b0;
`endif
  int total = 0, bad = 0;
  int cur_lit = -1;

  typedef struct { int val; bit last; int lit; } exp_t;
  exp_t exp_q[$];
  bit m_busy = 0, m_done = 0;
  int m_acc = 0;

  always #5 clk = ~clk;

  mod7681_msub_pipe #(.Q(Q), .N_COEFF(N), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .ri(ri), .a(a), .s(s),
`ifdef MSUB_ADD_MODE_EN
    .op(op),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_last(out_last),
    .busy(busy), .done(done)
  );

  function automatic int ref_msub(input int r, input int x, input int y);
    return ((r % Q) - ((x * y) % Q) + Q) % Q;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Reference model and compare, evaluated mid-cycle while everything is stable.
  always @(negedge clk) begin
    bit was_busy, nd;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      exp_q.delete();
      m_busy = 0; m_done = 0; m_acc = 0;
    end else begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("in_ready", in_ready, m_busy && m_acc < N && !(out_valid && !out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("result", result, exp_q[0].val);
          chk("out_last", out_last, exp_q[0].last);
          if (exp_q[0].lit >= 0) chk("result_lit", result, exp_q[0].lit);
        end
      end
      was_busy = m_busy;
      nd = 0;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        if (exp_q[0].last) begin m_busy = 0; nd = 1; end
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{ref_msub(ri, a, s), (m_acc == N - 1), cur_lit});
        m_acc++;
      end
      if (start && !was_busy) begin m_busy = 1; m_acc = 0; end
      m_done = nd;
    end
  end

  task automatic send(input int r, input int x, input int y, input int lit);
    logic hs;
    int n;
    n = 0;
    ri = 13'(r); a = 13'(x); s = 13'(y); cur_lit = lit; in_valid = 1'b1;
    forever begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
      if (hs) break;
      n++;
      if (n > 100) begin chk("send_timeout", 1, 0); break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (done !== 1'b1 && n < 60);
    start = 1'b0;
    chk("done_seen", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle: operands offered without start must be refused.
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;

    // Frame A: pinned values, latency, and start held through the final handshake.
    pulse_start();
    send(100, 3, 5, 85);
    lat = 0;
    do begin @(negedge clk); lat++; end while (out_valid !== 1'b1 && lat < 10);
    chk("latency", lat, 3);
    @(posedge clk); #1;
    send(10, 2, 10, 7671);
    send(0, 7680, 7680, 7680);
    send(8000, 0, 0, 319);
    start = 1'b1;
    wait_done();

    // Frame B: out-of-range operands, start during RUN, 5th operand refused.
    pulse_start();
    send(510, 8191, 1, 0);
    start = 1'b1;
    send(8191, 8191, 8191, -1);
    send(5, 2, 3, 7680);
    send(7000, 100, 50, 2000);
    start = 1'b0;
    in_valid = 1'b1; ri = 13'd1; a = 13'd1; s = 13'd1;
    repeat (2) begin @(negedge clk); chk("fifth_refused", in_ready, 0); end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_done();

    // Backpressure: 12 operands over 3 frames, out_ready low for two 5-cycle windows.
    fork
      for (int f = 0; f < 3; f++) begin
        pulse_start();
        for (int i = 0; i < N; i++) send(1000 * f + 37 * i, 7000 + 111 * i, 8191 - 50 * f - i, -1);
        wait_done();
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    // Reset mid-frame, then a fresh frame must count from zero.
    pulse_start();
    send(300, 7, 9, 237);
    send(4000, 2, 2000, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_start();
    send(1, 1, 1, 0);
    send(7680, 7680, 1, 0);
    send(8191, 0, 0, 510);
    send(0, 0, 0, 0);
    wait_done();
    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
